// File: rtl/fetch_decode_stage_if.sv
// Fetch/decode stage bus: hazard-controller controls, redirect, instruction memory, and the decode view.
// The slave modport is the stage; the master modport is the surrounding pipeline and the memory.
interface fetch_decode_stage_if;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc_32;
    logic [31:0] w_imem_data_32;
    logic [31:0] w_pc_32;
    logic [31:0] w_dinsn_32;
    logic [31:0] w_dpc_32;
    logic        w_dvalid;
    logic [4:0]  w_rs_addr_5;
    logic [4:0]  w_rt_addr_5;
    logic [4:0]  w_rd_addr_5;
    logic        w_alu_op;
    logic        w_imm_op;
    logic        w_jump_op;
    logic        w_mem_op;
    logic        w_write_op;
    logic [31:0] w_stall_count_32;

    modport master (
        output w_stall, w_redirect, w_redirect_pc_32, w_imem_data_32,
        input  w_pc_32, w_dinsn_32, w_dpc_32, w_dvalid,
        input  w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
        input  w_alu_op, w_imm_op, w_jump_op, w_mem_op, w_write_op,
        input  w_stall_count_32
    );

    modport slave (
        input  w_stall, w_redirect, w_redirect_pc_32, w_imem_data_32,
        output w_pc_32, w_dinsn_32, w_dpc_32, w_dvalid,
        output w_rs_addr_5, w_rt_addr_5, w_rd_addr_5,
        output w_alu_op, w_imm_op, w_jump_op, w_mem_op, w_write_op,
        output w_stall_count_32
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// Fetch + decode pipeline stage: PC sequencing with stall/redirect, a decode latch, op-class
// decode for the hazard controller, and a saturating stall-cycle counter.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
    input  logic                    clock,
    input  logic                    reset,
    fetch_decode_stage_if.slave     bus
);

    logic [31:0] pc;
    logic [31:0] dinsn;
    logic [31:0] dpc;
    logic        dvalid;
    logic [31:0] stall_count;

    // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= RESET_PC;
            dinsn  <= '0;
            dpc    <= '0;
            dvalid <= 1'b0;
        end else if (bus.w_redirect) begin
            pc     <= {bus.w_redirect_pc_32[31:2], 2'b00};
            dinsn  <= '0;
            dpc    <= '0;
            dvalid <= 1'b0;
        end else if (!bus.w_stall) begin
            pc     <= pc + 32'd4;
            dinsn  <= bus.w_imem_data_32;
            dpc    <= pc;
            dvalid <= 1'b1;
        end
    end

    // Stall cycles are counted even on redirect edges; the count sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (bus.w_stall && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
    end

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_op, imm_op, jump_op, mem_op, write_op;

    assign opcode = dinsn[31:26];
    assign funct  = dinsn[5:0];

    // NOTE: every decode output gets a default first so no path through the case infers a latch.
    always_comb begin
        alu_op   = 1'b0;
        imm_op   = 1'b0;
        jump_op  = 1'b0;
        mem_op   = 1'b0;
        write_op = 1'b0;
        if (dvalid) begin
            case (opcode)
                6'h00: begin
                    if (funct == 6'h08) jump_op = 1'b1;
                    else                alu_op  = 1'b1;
                end
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                    alu_op = 1'b1;
                    imm_op = 1'b1;
                end
                6'h23: begin
                    mem_op = 1'b1;
                    imm_op = 1'b1;
                end
                6'h2B: begin
                    mem_op   = 1'b1;
                    write_op = 1'b1;
                    imm_op   = 1'b1;
                end
                6'h02, 6'h03: jump_op = 1'b1;
                6'h04, 6'h05: begin
                    jump_op = 1'b1;
                    imm_op  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.w_pc_32          = pc;
    assign bus.w_dinsn_32       = dinsn;
    assign bus.w_dpc_32         = dpc;
    assign bus.w_dvalid         = dvalid;
    assign bus.w_rs_addr_5      = dinsn[25:21];
    assign bus.w_rt_addr_5      = dinsn[20:16];
    assign bus.w_rd_addr_5      = dinsn[15:11];
    assign bus.w_alu_op         = alu_op;
    assign bus.w_imm_op         = imm_op;
    assign bus.w_jump_op        = jump_op;
    assign bus.w_mem_op         = mem_op;
    assign bus.w_write_op       = write_op;
    assign bus.w_stall_count_32 = stall_count;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed-vector bench for fetch_decode_stage: the driver queues hand-computed post-edge state,
// the monitor pops one entry after every rising edge and compares it with the stage outputs.
module tb_fetch_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    // Flag vectors ordered {alu, imm, jump, mem, write}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_ALU  = 5'b10000;
    localparam logic [4:0] F_ALUI = 5'b11000;
    localparam logic [4:0] F_JMP  = 5'b00100;
    localparam logic [4:0] F_BR   = 5'b01100;
    localparam logic [4:0] F_LW   = 5'b01010;
    localparam logic [4:0] F_SW   = 5'b01011;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] dinsn;
        logic [31:0] dpc;
        logic        dvalid;
        logic [4:0]  flags;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    exp_t exp_q[$];

    fetch_decode_stage_if bus ();

    fetch_decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and queue the state expected after the next rising edge.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic [31:0] imem, input logic [31:0] e_pc, input logic [31:0] e_dinsn,
                       input logic [31:0] e_dpc, input logic e_dv, input logic [4:0] e_fl,
                       input logic [31:0] e_cnt);
        exp_t e;
        rst                  = r;
        bus.w_stall          = s;
        bus.w_redirect       = rd;
        bus.w_redirect_pc_32 = rpc;
        bus.w_imem_data_32   = imem;
        e.id     = vec_id;
        e.pc     = e_pc;
        e.dinsn  = e_dinsn;
        e.dpc    = e_dpc;
        e.dvalid = e_dv;
        e.flags  = e_fl;
        e.cnt    = e_cnt;
        exp_q.push_back(e);
        vec_id++;
        @(negedge clk);
    endtask

    task automatic adv(input logic [31:0] imem, input logic [31:0] e_pc, input logic [31:0] e_dpc,
                       input logic [4:0] e_fl, input logic [31:0] e_cnt);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, imem, e_pc, imem, e_dpc, 1'b1, e_fl, e_cnt);
    endtask

    // Monitor: one expectation per rising edge while any are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("v%0d pc", e.id),     bus.w_pc_32,      e.pc);
                check($sformatf("v%0d dinsn", e.id),  bus.w_dinsn_32,   e.dinsn);
                check($sformatf("v%0d dpc", e.id),    bus.w_dpc_32,     e.dpc);
                check($sformatf("v%0d dvalid", e.id), 32'(bus.w_dvalid), 32'(e.dvalid));
                check($sformatf("v%0d flags", e.id),
                      32'({bus.w_alu_op, bus.w_imm_op, bus.w_jump_op, bus.w_mem_op, bus.w_write_op}),
                      32'(e.flags));
                check($sformatf("v%0d regs", e.id),
                      32'({bus.w_rs_addr_5, bus.w_rt_addr_5, bus.w_rd_addr_5}),
                      32'({e.dinsn[25:21], e.dinsn[20:16], e.dinsn[15:11]}));
                check($sformatf("v%0d stall_count", e.id), bus.w_stall_count_32, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                  = 1'b1;
        bus.w_stall          = 1'b0;
        bus.w_redirect       = 1'b0;
        bus.w_redirect_pc_32 = '0;
        bus.w_imem_data_32   = '0;
        @(negedge clk);

        // Reset wins over redirect and stall
        cyc(1, 1, 1, 32'h0000_0123, 32'hDEAD_BEEF, RESET_PC, 32'h0, 32'h0, 0, F_NONE, 32'd0);
        cyc(1, 0, 0, 32'h0, 32'hDEAD_BEEF, RESET_PC, 32'h0, 32'h0, 0, F_NONE, 32'd0);

        // Straight-line fetch
        adv(32'h8C22_0004, 32'h0100_0004, 32'h0100_0000, F_LW, 32'd0);
        adv(32'h0085_1020, 32'h0100_0008, 32'h0100_0004, F_ALU, 32'd0);

        // Three stall cycles freeze the stage, then advance resumes
        cyc(0, 1, 0, 32'h0, 32'hAC43_0008, 32'h0100_0008, 32'h0085_1020, 32'h0100_0004, 1, F_ALU, 32'd1);
        cyc(0, 1, 0, 32'h0, 32'hAC43_0008, 32'h0100_0008, 32'h0085_1020, 32'h0100_0004, 1, F_ALU, 32'd2);
        cyc(0, 1, 0, 32'h0, 32'hAC43_0008, 32'h0100_0008, 32'h0085_1020, 32'h0100_0004, 1, F_ALU, 32'd3);
        adv(32'hAC43_0008, 32'h0100_000C, 32'h0100_0008, F_SW, 32'd3);

        // Redirect with stall: aligned target, bubble, stall still counted
        cyc(0, 1, 1, 32'h0040_0013, 32'h8C22_0004, 32'h0040_0010, 32'h0, 32'h0, 0, F_NONE, 32'd4);

        // Decode sweep, including the all-zero nop and unlisted opcodes
        adv(32'h0000_0000, 32'h0040_0014, 32'h0040_0010, F_ALU,  32'd4);
        adv(32'h03E0_0008, 32'h0040_0018, 32'h0040_0014, F_JMP,  32'd4);
        adv(32'h2022_0005, 32'h0040_001C, 32'h0040_0018, F_ALUI, 32'd4);
        adv(32'h3C01_1234, 32'h0040_0020, 32'h0040_001C, F_ALUI, 32'd4);
        adv(32'h0810_0000, 32'h0040_0024, 32'h0040_0020, F_JMP,  32'd4);
        adv(32'h0C10_0000, 32'h0040_0028, 32'h0040_0024, F_JMP,  32'd4);
        adv(32'h1022_FFFE, 32'h0040_002C, 32'h0040_0028, F_BR,   32'd4);
        adv(32'h1422_0003, 32'h0040_0030, 32'h0040_002C, F_BR,   32'd4);
        adv(32'hFC00_0000, 32'h0040_0034, 32'h0040_0030, F_NONE, 32'd4);
        adv(32'h1C00_0000, 32'h0040_0038, 32'h0040_0034, F_NONE, 32'd4);
        adv(32'h4000_0000, 32'h0040_003C, 32'h0040_0038, F_NONE, 32'd4);

        // Wrap past the top of the address space
        cyc(0, 0, 1, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, F_NONE, 32'd4);
        adv(32'h0085_1020, 32'h0000_0000, 32'hFFFF_FFFC, F_ALU, 32'd4);
        adv(32'h8C22_0004, 32'h0000_0004, 32'h0000_0000, F_LW,  32'd4);

        // Saturation: preload the counter one below all-ones, then keep stalling
        force dut.stall_count = 32'hFFFF_FFFE;
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0000_0004, 32'h8C22_0004, 32'h0, 1, F_LW, 32'hFFFF_FFFE);
        release dut.stall_count;
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0000_0004, 32'h8C22_0004, 32'h0, 1, F_LW, 32'hFFFF_FFFF);
        cyc(0, 1, 0, 32'h0, 32'h0, 32'h0000_0004, 32'h8C22_0004, 32'h0, 1, F_LW, 32'hFFFF_FFFF);

        // Reset mid-stall, then the first fetch at RESET_PC one edge later
        cyc(1, 1, 0, 32'h0, 32'h0, RESET_PC, 32'h0, 32'h0, 0, F_NONE, 32'd0);
        adv(32'h8C22_0004, 32'h0100_0004, 32'h0100_0000, F_LW, 32'd0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0100_0000: fetch address loaded on reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port w_stall  input  1  hold request from hazard detection controller.
REQ-006 SHALL have port w_redirect  input  1  taken branch/jump from execute; squash and refetch.
REQ-007 SHALL have port w_redirect_pc_32  input  32  redirect target address.
REQ-008 SHALL have port w_imem_data_32  input  32  instruction memory read data, combinational from w_pc_32.
REQ-009 SHALL have port w_pc_32  output  32  current fetch address.
REQ-010 SHALL have port w_dinsn_32  output  32  instruction latched in decode.
REQ-011 SHALL have port w_dpc_32  output  32  address of w_dinsn_32.
REQ-012 SHALL have port w_dvalid  output  1  decode slot holds a real instruction.
REQ-013 SHALL have ports w_rs_addr_5, w_rt_addr_5, w_rd_addr_5  output  5 each  fields [25:21], [20:16], [15:11] of w_dinsn_32.
REQ-014 SHALL have ports w_alu_op, w_imm_op, w_jump_op, w_mem_op, w_write_op  output  1 each  op-class flags for the hazard controller.
REQ-015 SHALL have port w_stall_count_32  output  32  saturating count of stall cycles.

Function
REQ-016 SHALL apply per-edge priority reset > w_redirect > w_stall > normal advance.
REQ-017 SHALL on normal advance load w_dinsn_32<=w_imem_data_32, w_dpc_32<=w_pc_32, w_dvalid<=1, w_pc_32<=w_pc_32+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 SHALL give one-cycle fetch-to-decode latency: the instruction at address A appears in decode on the edge after w_pc_32==A with no stall or redirect.
REQ-019 SHALL on stall without redirect hold w_pc_32, w_dinsn_32, w_dpc_32, and w_dvalid unchanged.
REQ-020 SHALL on redirect load w_pc_32<={w_redirect_pc_32[31:2],2'b00}, set w_dinsn_32<=0, w_dpc_32<=0, w_dvalid<=0 (bubble), whether or not w_stall is asserted.
REQ-021 SHALL increment w_stall_count_32 on every edge with w_stall=1 and reset=0, including redirect edges, saturating at 32'hFFFF_FFFF.
REQ-022 SHALL decode flags combinationally from w_dinsn_32 opcode [31:26] and funct [5:0]:
- opcode 0, funct!=0x08: alu=1.
- opcode 0, funct 0x08 (jr): jump=1.
- opcode 0x08-0x0F: alu=1, imm=1.
- opcode 0x23 (lw): mem=1, imm=1.
- opcode 0x2B (sw): mem=1, write=1, imm=1.
- opcode 0x02/0x03 (j/jal): jump=1.
- opcode 0x04/0x05 (beq/bne): jump=1, imm=1.
- all other flags 0.
REQ-023 SHALL force all five flags to 0 for unlisted opcodes and whenever w_dvalid=0.
REQ-024 SHALL drive register address outputs from w_dinsn_32 fields regardless of w_dvalid; a bubble therefore yields 0,0,0.
REQ-025 SHALL treat instruction word 32'h0000_0000 with w_dvalid=1 as a valid R-type (alu=1), i.e. sll $0 nop.
REQ-026 SHALL contain no combinational path from any input to any output except flag and address decode from registered w_dinsn_32.

Reset
REQ-027 SHALL on reset set w_pc_32=RESET_PC, w_dinsn_32=0, w_dpc_32=0, w_dvalid=0, w_stall_count_32=0, overriding w_redirect and w_stall in the same cycle.
REQ-028 SHALL accept reset mid-operation at any edge with identical result; first fetch at RESET_PC enters decode one edge after reset deasserts.

Verification
REQ-029 SHALL cover straight-line fetch: imem returns 32'h8C22_0004 at 0x0100_0000, no stall -> next edge dinsn=8C220004, dpc=0100_0000, dvalid=1, mem=1, imm=1, write=0, rs=1, rt=2, pc=0100_0004.
REQ-030 SHALL cover stall: w_stall held 3 cycles -> pc, dinsn, dpc frozen; stall_count=3; advance resumes on first edge with w_stall=0.
REQ-031 SHALL cover redirect with stall: w_stall=1, w_redirect=1, target 32'h0040_0013 -> pc=0040_0010, dvalid=0, all flags 0, stall_count+1.
REQ-032 SHALL cover wrap: pc=FFFF_FFFC, advance -> pc=0000_0000, dpc=FFFF_FFFC.
REQ-033 SHALL cover decode sweep: each opcode class in REQ-022 plus jr (32'h03E0_0008) and an illegal opcode 0x3F -> exact flag vectors; illegal gives all 0.
REQ-034 SHALL cover reset mid-stall with stall_count preloaded to FFFF_FFFF via 2^32 stall cycles or force -> saturation holds, then reset -> count=0, pc=RESET_PC, dvalid=0.
